// File: rtl/rra_pkg.sv
// Shared constants and helpers for the round-robin request queue and its arbiter.
package rra_pkg;

  localparam int REQS_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Zero is not one-hot; v & (v-1) clears the lowest set bit.
  function automatic logic is_onehot(input logic [REQS_DEF-1:0] v);
    return (v != '0) && ((v & (v - {{(REQS_DEF-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/rr_req_queue_if.sv
// Push side, arbiter req/grant and popped-beat output of the request queue.
interface rr_req_queue_if
  import rra_pkg::*;
#(
  parameter int REQS = REQS_DEF,
  parameter int DW   = DW_DEF
);
  logic [REQS-1:0]             push;
  logic [REQS*DW-1:0]          push_data;
  logic [REQS-1:0]             full;
  logic [REQS-1:0]             req;
  logic [REQS-1:0]             grant;
  logic                        out_valid;
  logic [DW-1:0]               out_data;
  logic [id_width(REQS)-1:0]   out_id;
  logic                        gnt_err;
  logic [REQS-1:0]             ovf;

  modport master (
    output push, push_data, grant,
    input  full, req, out_valid, out_data, out_id, gnt_err, ovf
  );

  modport slave (
    input  push, push_data, grant,
    output full, req, out_valid, out_data, out_id, gnt_err, ovf
  );
endinterface

// File: rtl/req_fifo.sv
// One requester channel: circular buffer with pointers, occupancy count and drop flag.
module req_fifo
  import rra_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          ovf_reg;
  logic          wr_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  // A pop frees a slot in the same cycle, so a full channel still accepts a push.
  assign wr_en = push & (~full | pop);
  assign dout  = mem[rd_ptr_reg];
  assign ovf   = ovf_reg;

  always_comb begin
    count_next = count_reg;
    if (wr_en && !pop)
      count_next = count_reg + (AW+1)'(1);
    else if (pop && !wr_en)
      count_next = count_reg - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      ovf_reg   <= push & full & ~pop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/rr_req_queue.sv
// Per-requester FIFOs feeding the round-robin arbiter; pops the granted channel
// and registers the popped payload and requester index.
module rr_req_queue
  import rra_pkg::*;
#(
  parameter int REQS  = REQS_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  rr_req_queue_if.slave  bus
);
  localparam int IW = id_width(REQS);

  logic [REQS-1:0] empty, full, ovf, pop;
  logic [DW-1:0]   dout [REQS];
  logic            grant_onehot;
  logic [DW-1:0]   data_next, out_data_reg;
  logic [IW-1:0]   id_next, out_id_reg;
  logic            err_next, out_valid_reg, gnt_err_reg;

  assign grant_onehot = is_onehot(bus.grant);

  generate
    for (genvar gi = 0; gi < REQS; gi++) begin : g_ch
      assign pop[gi] = bus.grant[gi] & grant_onehot & ~empty[gi];

      req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push[gi]),
        .din   (bus.push_data[gi*DW +: DW]),
        .pop   (pop[gi]),
        .dout  (dout[gi]),
        .empty (empty[gi]),
        .full  (full[gi]),
        .ovf   (ovf[gi])
      );
    end
  endgenerate

  assign bus.req  = ~empty;
  assign bus.full = full;
  assign bus.ovf  = ovf;

  // pop is one-hot or zero, so OR-ing the selected lanes acts as a mux.
  always_comb begin
    data_next = '0;
    id_next   = '0;
    for (int i = 0; i < REQS; i++) begin
      if (pop[i]) begin
        data_next = data_next | dout[i];
        id_next   = id_next | IW'(i);
      end
    end
    err_next = (bus.grant != '0) & ~(|pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      gnt_err_reg   <= 1'b0;
    end else begin
      out_valid_reg <= |pop;
      gnt_err_reg   <= err_next;
      if (|pop) begin
        out_data_reg <= data_next;
        out_id_reg   <= id_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.gnt_err   = gnt_err_reg;

endmodule

// File: tb/tb_rr_req_queue.sv
// Scoreboard bench for rr_req_queue: queue model per channel plus a lagging arbiter model.
module tb_rr_req_queue;
  import rra_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_req_queue_if #(.REQS(4), .DW(8)) bus ();

  rr_req_queue #(.REQS(4), .DW(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  logic [7:0] mq [4][$];
  logic [9:0] scb [$];
  logic [3:0] rq1, rq2, g;
  int ptr, j;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic step(input logic [3:0] pv, input logic [31:0] pd, input logic [3:0] gv);
    logic [3:0] exp_ovf, exp_req, exp_full;
    logic       any_pop, fb, popi, oh;
    logic [7:0] d;
    logic [9:0] e;
    bus.push      = pv;
    bus.push_data = pd;
    bus.grant     = gv;
    oh = is_onehot(gv);
    any_pop = 1'b0;
    exp_ovf = '0;
    for (int i = 0; i < 4; i++) begin
      fb   = (mq[i].size() == 4);
      popi = gv[i] && oh && (mq[i].size() != 0);
      if (popi) begin
        d = mq[i].pop_front();
        scb.push_back({2'(i), d});
        any_pop = 1'b1;
      end
      if (pv[i]) begin
        if (!fb || popi) mq[i].push_back(pd[i*8 +: 8]);
        else exp_ovf[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("ovf", 32'(bus.ovf), 32'(exp_ovf));
    check("gnt_err", 32'(bus.gnt_err), 32'((gv != 0) && !any_pop));
    check("out_valid", 32'(bus.out_valid), 32'(any_pop));
    if (bus.out_valid) begin
      if (scb.size() == 0) begin
        check("scb_empty", 32'(scb.size()), 32'd1);
      end else begin
        e = scb.pop_front();
        $display("pop id=%0d data=%02h (exp id=%0d data=%02h)", bus.out_id, bus.out_data, e[9:8], e[7:0]);
        check("out_data", 32'(bus.out_data), 32'(e[7:0]));
        check("out_id", 32'(bus.out_id), 32'(e[9:8]));
        delivered++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_req[i]  = (mq[i].size() != 0);
      exp_full[i] = (mq[i].size() == 4);
    end
    check("req", 32'(bus.req), 32'(exp_req));
    check("full", 32'(bus.full), 32'(exp_full));
  endtask

  initial begin
    bus.push = 4'hF;
    bus.push_data = 32'hDEADBEEF;
    bus.grant = 4'h0;

    // Reset held with pushes active
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_id", 32'(bus.out_id), 32'd0);
    check("rst_gnt_err", 32'(bus.gnt_err), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    bus.push = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(4'h0, 32'h0, 4'h0);

    // Channel 2 FIFO order
    step(4'b0100, 32'h0011_0000, 4'h0);
    step(4'b0100, 32'h0022_0000, 4'h0);
    step(4'b0100, 32'h0033_0000, 4'h0);
    repeat (3) step(4'h0, 32'h0, 4'b0100);
    step(4'h0, 32'h0, 4'h0);

    // Channel 0 fill, overflow, drain, then a late grant on empty
    for (int k = 0; k < 5; k++) step(4'b0001, 32'(8'hA0 + k), 4'h0);
    repeat (4) step(4'h0, 32'h0, 4'b0001);
    step(4'h0, 32'h0, 4'b0001);

    // Channel 1 full with push and pop together
    for (int k = 0; k < 4; k++) step(4'b0010, 32'(8'hB0 + k) << 8, 4'h0);
    step(4'b0010, 32'h0000_AA00, 4'b0010);
    repeat (4) step(4'h0, 32'h0, 4'b0010);

    // Illegal multi-bit grant and grant on an empty channel
    step(4'b0011, 32'h0000_C2C1, 4'h0);
    step(4'h0, 32'h0, 4'b0011);
    step(4'h0, 32'h0, 4'b1000);
    step(4'h0, 32'h0, 4'b0001);
    step(4'h0, 32'h0, 4'b0010);

    // Integration with a round-robin arbiter whose grant lags req by two cycles
    delivered = 0;
    step(4'hF, 32'h1312_1110, 4'h0);
    rq2 = bus.req;
    step(4'hF, 32'h2322_2120, 4'h0);
    rq1 = bus.req;
    ptr = 0;
    for (int c = 0; c < 40 && delivered < 8; c++) begin
      g = 4'h0;
      for (int k = 0; k < 4; k++) begin
        j = (ptr + k) % 4;
        if (g == 4'h0 && rq2[j]) begin
          g = 4'(1 << j);
          ptr = (j + 1) % 4;
        end
      end
      step(4'h0, 32'h0, g);
      rq2 = rq1;
      rq1 = bus.req;
    end
    check("delivered", 32'(delivered), 32'd8);
    check("scb_drained", 32'(scb.size()), 32'd0);

    // Asynchronous reset mid-stream
    step(4'hF, 32'h3332_3130, 4'h0);
    step(4'hF, 32'h4342_4140, 4'h0);
    step(4'h0, 32'h0, 4'b0001);
    bus.grant = 4'b0010;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.req), 32'd0);
    check("mid_rst_full", 32'(bus.full), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_out_id", 32'(bus.out_id), 32'd0);
    for (int i = 0; i < 4; i++) mq[i].delete();
    scb.delete();
    bus.grant = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step(4'h0, 32'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_req_queue.md
Name: rr_req_queue

Overview:
- Upstream feeder for the 4-way round-robin arbiter: one small FIFO per requester buffers transaction payloads.
- Drives the arbiter's req vector, with req[i] high while FIFO i is non-empty.
- Pops the FIFO named by the arbiter's one-hot grant and presents the popped payload plus requester ID as a registered single-beat output to the shared resource.

Parameters:
REQS, 4, number of requesters; must match the arbiter's REQS (4 only, since the arbiter is hard-coded to 4).
DW, 8, payload width per entry in bits.
DEPTH, 4, entries per requester FIFO; power of two, at least 2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
push  input  REQS  per-requester write strobe.
push_data  input  REQS*DW  packed payloads; slice i is bits [i*DW +: DW].
full  output  REQS  FIFO i holds DEPTH entries.
req  output  REQS  to arbiter req; req[i] = FIFO i non-empty.
grant  input  REQS  from arbiter grant; one-hot or zero.
out_valid  output  1  one-cycle pulse: payload popped last cycle.
out_data  output  DW  popped payload; valid when out_valid = 1.
out_id  output  clog2(REQS)  index of the popped requester.
gnt_err  output  1  one-cycle pulse: illegal or empty grant seen last cycle.
ovf  output  REQS  one-cycle pulse per channel: push dropped.

Behaviour:
- Reset (rst = 0, asynchronous) clears all channels and outputs:
  - all read pointers, write pointers and counts go to 0;
  - req = 0, full = 0, out_valid = 0, out_data = 0, out_id = 0, gnt_err = 0, ovf = 0.
  - Reset mid-operation discards all queued entries, and no out_valid follows reset release.
- Per-channel FIFO:
  - wr_ptr, rd_ptr and count are registered; width of count is clog2(DEPTH)+1.
  - req[i] = (count_i != 0) and full[i] = (count_i == DEPTH); both are combinational from registered state only, never from grant or push.
- Pop qualification, evaluated each cycle:
  - pop_i = grant[i] & grant is one-hot & count_i != 0.
  - Zero grant: idle, no error.
  - More than one bit set in grant: no pop on any channel; gnt_err = 1 next cycle.
  - One-hot grant on an empty channel: no pop; gnt_err = 1 next cycle. This is expected after a last-entry pop, because the arbiter's grant lags req by two cycles.
- Output on a pop, registered with one cycle latency (grant at edge N gives out_valid high after edge N+1):
  - out_valid = 1, out_data = mem_i[rd_ptr_i], out_id = i.
  - Without a pop, out_valid = 0 and out_data/out_id hold their previous values.
- Push:
  - Accepted when push[i] & (!full[i] | pop_i); the entry is written at wr_ptr_i.
  - If push[i] & full[i] & !pop_i, the entry is dropped and ovf[i] = 1 next cycle.
- Simultaneous push and pop on the same channel: both happen; count unchanged; pointers both advance.
  - When count = 0, there is no pop, so the push simply lands.
  - Data is never bypassed: a push is visible to pop no earlier than the next cycle.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH and never goes below 0.
- Ordering: within a channel, strictly FIFO; across channels, order is set entirely by the arbiter.

Decomposition:
- Shared package rra_pkg holds:
  - REQS_DEF = 4, DW_DEF = 8, DEPTH_DEF = 4;
  - the ID width function (clog2);
  - a one-hot check function reused by the arbiter bench.
- Sub-module req_fifo holds one channel's storage, pointers, count, full/empty and ovf logic.
  - Ports: clk, rst, push, din, pop, dout, empty, full, ovf.
  - Instantiated REQS times in a generate loop.
- Top level holds grant qualification, the output register and gnt_err.

Test Plan:
- Reset: hold rst = 0 with push = 4'b1111 → req = 0, full = 0, out_valid = 0; after release and no push, req stays 0 indefinitely.
- Single channel FIFO order:
  - Push 0x11, 0x22, 0x33 on ch2, then grant = 4'b0100 for 3 cycles → out_data 0x11, 0x22, 0x33, out_id = 2 each, one cycle after each grant.
  - req[2] falls the cycle after the third pop.
- Full and overflow:
  - 5 pushes on ch0 with no grant → full[0] = 1 after the 4th; the 5th raises ovf[0] = 1 for one cycle.
  - Popping then yields exactly the first 4 values.
- Push on full with simultaneous pop: ch1 full, push 0xAA while grant = 4'b0010 → no ovf; count stays 4; 0xAA emerges as the 4th pop after that.
- Illegal and late grants:
  - grant = 4'b0011 with both channels non-empty → gnt_err pulse, both counts unchanged.
  - grant = 4'b1000 with ch3 empty → gnt_err pulse, out_valid = 0.
- Integration with the arbiter (REQS = 4):
  - Load ch0..ch3 with 2 entries each → all 8 payloads delivered, each exactly once.
  - Channel order per rotation is 0, 1, 2, 3; a gnt_err is tolerated only after a channel empties.
  - Assert async reset mid-stream → outputs clear immediately.
